ov5640_rgb565_capture: RTL
==========================

# ov5640_rgb565_capture

Camera-side capture stage placed directly downstream of the OV5640 configuration/capture block. It runs in the camera pixel-clock domain and turns the raw 8-bit DVP byte stream (vsync/href/data) into framed RGB888 pixels with X/Y coordinates and frame markers. Frames are emitted only after sensor configuration completes and a programmable number of warm-up frames has been discarded. It is the source for the later frame-buffer and CV stages, which will replace the HDMI test pattern.

## Interface
- H_RES, 1280: active pixels per line (1..4095).
- V_RES, 720: active lines per frame (1..4095).
- SKIP_FRAMES, 10: whole frames discarded after `I_cfg_done` (0..255).
- VS_POL, 1: vsync active level; 1 means vsync high marks the frame gap.

Ports:
- I_clk  in  1  camera pixel clock (cmos_pclk); the only clock.
- I_rst  in  1  asynchronous active-high reset.
- I_cfg_done  in  1  sensor register configuration complete (level).
- I_vsync  in  1  camera vsync.
- I_href  in  1  camera href; qualifies data bytes.
- I_data  in  8  camera data byte.
- O_pix_valid  out  1  one-cycle strobe; pixel outputs are valid.
- O_pix_r / O_pix_g / O_pix_b  out  8 each  RGB888 pixel.
- O_x  out  12  pixel column, 0..H_RES-1.
- O_y  out  12  pixel line, 0..V_RES-1.
- O_sof  out  1  with O_pix_valid, first pixel of the frame (x=0, y=0).
- O_eol  out  1  with O_pix_valid, last pixel of the line (x=H_RES-1).
- O_eof  out  1  with O_pix_valid, last pixel of the frame.
- O_frame_cnt  out  16  emitted complete frames; wraps at 65535 to 0.
- O_err_line  out  1  one-cycle pulse on a bad line length.
- O_err_frame  out  1  one-cycle pulse on a bad line count.
- O_err_sticky  out  1  OR of all errors since reset.

## Operation
- Inputs (vsync, href, data) are registered once at the input before any use. All decisions use the registered values.
- "vs_act" is the registered vsync compared against VS_POL. The frame boundary is the cycle in which vs_act falls.
- FSM states:
  - WAIT_CFG: entered from reset. Moves to SYNC when I_cfg_done=1.
  - SYNC: waits for a frame boundary, then goes to SKIP if SKIP_FRAMES>0, otherwise to ACTIVE.
  - SKIP: counts frame boundaries. After the SKIP_FRAMES-th boundary it goes to ACTIVE.
  - ACTIVE: emits pixels.
- I_cfg_done=0 in any state forces WAIT_CFG on the next edge. Any partial frame is abandoned with no error and no markers.
- Byte pairing in ACTIVE:
  - A phase bit clears when href is low and toggles on each href-high byte.
  - The even-phase byte is hi = {R[4:0], G[5:3]}. The odd-phase byte is lo = {G[2:0], B[4:0]}.
- RGB565 to RGB888 expansion:
  - R8 = {R5, R5[4:2]}.
  - G8 = {G6, G6[5:4]}.
  - B8 = {B5, B5[4:2]}.
- Counters: x increments per assembled pixel and clears at the href falling edge. y increments at each href falling edge and clears at the frame boundary.
- Pixels with x ≥ H_RES or y ≥ V_RES are counted but not emitted.
- Line check at the href falling edge in ACTIVE, only for lines with y < V_RES: pulse O_err_line if the pixel count ≠ H_RES or an odd byte is left over. That line's y still increments.
- Frame check at the frame boundary while in ACTIVE: pulse O_err_frame if the line count ≠ V_RES.
- O_frame_cnt increments on the cycle O_eof is emitted.
- href high while vs_act=1 is ignored: no pixels, no counting.
- If the frame boundary and the href falling edge occur in the same cycle, the frame boundary wins. y clears, and the line check is skipped.

## Timing
- Reset values: all outputs are 0. FSM is WAIT_CFG; phase, x, y, skip and frame counters are 0.
- Latency: O_pix_valid, data, coordinates and markers are asserted on the 2nd rising edge after the edge that samples the lo byte on I_data. This is one input-register stage plus one output-register stage.
- Throughput: at most one pixel every 2 clocks, so O_pix_valid is never high on two consecutive cycles.
- Marker timing: O_sof, O_eol and O_eof are only ever high together with O_pix_valid.
- Error pulse timing: O_err_line and O_err_frame are asserted 2 edges after the causing href or vsync sample.
- O_err_sticky rises on the same edge as the pulse that sets it.
- Reset mid-frame: outputs drop asynchronously. After release the block re-runs WAIT_CFG, SYNC and SKIP, so no partial frame is ever emitted.

## Test plan
- Setup: H_RES=4, V_RES=2, SKIP_FRAMES=1. Drive a clean 4x2 frame with bytes hi=0xF8, lo=0x00 after one skipped frame.
  - Expect exactly 8 strobes of R=0xFF, G=0x00, B=0x00.
  - O_sof at (0,0), O_eol at x=3, O_eof at (3,1), O_frame_cnt=1, no errors.
- Byte 0x07,0xE0 → G=0xFF, R=B=0. Byte 0x00,0x1F → B=0xFF. Byte 0x84,0x10 → R=0x84, G=0x82, B=0x84.
  - Check the 2-cycle latency from the lo byte sample.
- Line of 5 pixels (then a line of 3 plus an odd byte):
  - 5 pixels: 4 strobes, no strobe for x=4, O_err_line pulse, sticky=1.
  - 3 pixels plus odd byte: O_err_line pulse.
- Frame of only 1 line → O_err_frame at the boundary, O_frame_cnt unchanged. Frame of 3 lines → third line suppressed and O_err_frame.
- I_cfg_done held low for 2 frames → zero strobes. Then raise it → first output only after SYNC plus 1 skipped frame.
- Assert I_rst mid-line of an active frame → all outputs 0 immediately. The rest of that frame produces no strobes, and O_frame_cnt restarts at 0.

Source files
------------

// File: rtl/ov5640_rgb565_capture.sv
// Camera-side capture stage: pairs OV5640 RGB565 DVP bytes into RGB888 pixels
// with X/Y coordinates, frame markers and line/frame length checking.
module ov5640_rgb565_capture #(
  parameter int H_RES       = 1280,
  parameter int V_RES       = 720,
  parameter int SKIP_FRAMES = 10,
  parameter int VS_POL      = 1
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_cfg_done,
  input  logic        I_vsync,
  input  logic        I_href,
  input  logic [7:0]  I_data,
  output logic        O_pix_valid,
  output logic [7:0]  O_pix_r,
  output logic [7:0]  O_pix_g,
  output logic [7:0]  O_pix_b,
  output logic [11:0] O_x,
  output logic [11:0] O_y,
  output logic        O_sof,
  output logic        O_eol,
  output logic        O_eof,
  output logic [15:0] O_frame_cnt,
  output logic        O_err_line,
  output logic        O_err_frame,
  output logic        O_err_sticky
);

  localparam logic [11:0] LP_H         = 12'(H_RES);
  localparam logic [11:0] LP_V         = 12'(V_RES);
  localparam logic [11:0] LP_H_M1      = 12'(H_RES - 1);
  localparam logic [11:0] LP_V_M1      = 12'(V_RES - 1);
  localparam logic [7:0]  LP_SKIP_LAST = 8'(SKIP_FRAMES - 1);
  localparam logic        LP_VS_POL    = 1'(VS_POL);

  typedef enum logic [1:0] {S_WAIT_CFG, S_SYNC, S_SKIP, S_ACTIVE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_vsync;
  logic        r_href;
  logic [7:0]  r_data;
  logic        r_vs_act_d;
  logic        r_hq_d;
  logic [7:0]  r_skip_cnt;
  logic        r_phase;
  logic [7:0]  r_hi;
  logic [11:0] r_x;
  logic [11:0] r_y;

  logic        w_vs_act;
  logic        w_hq;
  logic        w_frame_bd;
  logic        w_line_end;
  logic        w_active;
  logic        w_pix_done;
  logic        w_emit;
  logic        w_last_x;
  logic        w_eof;
  logic        w_line_err;
  logic        w_frame_err;
  logic [4:0]  w_r5;
  logic [5:0]  w_g6;
  logic [4:0]  w_b5;

  // href is only meaningful outside the vsync gap; edges are taken on that qualified level
  assign w_vs_act   = (r_vsync == LP_VS_POL);
  assign w_hq       = r_href & ~w_vs_act;
  assign w_frame_bd = r_vs_act_d & ~w_vs_act;
  assign w_line_end = r_hq_d & ~w_hq;
  assign w_active   = (r_state == S_ACTIVE) & I_cfg_done;

  assign w_pix_done = w_active & ~w_frame_bd & w_hq & r_phase;
  assign w_emit     = w_pix_done & (r_x < LP_H) & (r_y < LP_V);
  assign w_last_x   = (r_x == LP_H_M1);
  assign w_eof      = w_emit & w_last_x & (r_y == LP_V_M1);

  assign w_r5 = r_hi[7:3];
  assign w_g6 = {r_hi[2:0], r_data[7:5]};
  assign w_b5 = r_data[4:0];

  assign w_line_err  = w_active & w_line_end & ~w_frame_bd & (r_y < LP_V) &
                       ((r_x != LP_H) | r_phase);
  assign w_frame_err = w_active & w_frame_bd & (r_y != LP_V);

  // Inactive vsync level on reset so release never fakes a frame boundary
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_vsync    <= ~LP_VS_POL;
      r_href     <= 1'b0;
      r_data     <= '0;
      r_vs_act_d <= 1'b0;
      r_hq_d     <= 1'b0;
    end else begin
      r_vsync    <= I_vsync;
      r_href     <= I_href;
      r_data     <= I_data;
      r_vs_act_d <= w_vs_act;
      r_hq_d     <= w_hq;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) r_state <= S_WAIT_CFG;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!I_cfg_done) begin
      w_next = S_WAIT_CFG;
    end else begin
      case (r_state)
        S_WAIT_CFG: w_next = S_SYNC;
        S_SYNC:     if (w_frame_bd) w_next = (SKIP_FRAMES == 0) ? S_ACTIVE : S_SKIP;
        S_SKIP:     if (w_frame_bd && (r_skip_cnt == LP_SKIP_LAST)) w_next = S_ACTIVE;
        S_ACTIVE:   w_next = S_ACTIVE;
        default:    w_next = S_WAIT_CFG;
      endcase
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst)                    r_skip_cnt <= '0;
    else if (r_state != S_SKIP)   r_skip_cnt <= '0;
    else if (w_frame_bd)          r_skip_cnt <= r_skip_cnt + 8'd1;
  end

  // Counters saturate so an overlong line can never wrap back onto a legal count
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_phase <= 1'b0;
      r_hi    <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (!w_active || w_frame_bd) begin
      r_phase <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      if (w_hq) begin
        r_phase <= ~r_phase;
        if (!r_phase)             r_hi <= r_data;
        else if (r_x != 12'hFFF)  r_x  <= r_x + 12'd1;
      end else begin
        r_phase <= 1'b0;
      end
      if (w_line_end) begin
        r_x <= '0;
        if (r_y != 12'hFFF) r_y <= r_y + 12'd1;
      end
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      O_pix_valid  <= 1'b0;
      O_pix_r      <= '0;
      O_pix_g      <= '0;
      O_pix_b      <= '0;
      O_x          <= '0;
      O_y          <= '0;
      O_sof        <= 1'b0;
      O_eol        <= 1'b0;
      O_eof        <= 1'b0;
      O_frame_cnt  <= '0;
      O_err_line   <= 1'b0;
      O_err_frame  <= 1'b0;
      O_err_sticky <= 1'b0;
    end else begin
      O_pix_valid <= w_emit;
      O_sof       <= w_emit & (r_x == 12'd0) & (r_y == 12'd0);
      O_eol       <= w_emit & w_last_x;
      O_eof       <= w_eof;
      if (w_emit) begin
        O_pix_r <= {w_r5, w_r5[4:2]};
        O_pix_g <= {w_g6, w_g6[5:4]};
        O_pix_b <= {w_b5, w_b5[4:2]};
        O_x     <= r_x;
        O_y     <= r_y;
      end
      if (w_eof) O_frame_cnt <= O_frame_cnt + 16'd1;
      O_err_line  <= w_line_err;
      O_err_frame <= w_frame_err;
      if (w_line_err || w_frame_err) O_err_sticky <= 1'b1;
    end
  end

endmodule
